rptr_empty: RTL
===============

// Module: rptr_empty
// PURPOSE
//  Read-domain pointer and empty-flag controller for the async FIFO; the read-side counterpart
//  of the write-domain synchronizer path. Brings the Gray write pointer into rclk through an
//  internal two-flop synchronizer, advances the Gray/binary read pointer, and drives RAM read
//  address, registered empty / almost-empty, a conservative fill level and a sticky underflow flag.
// PARAMETERS
//  ADDRSIZE       6   FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits (extra wrap bit)
//  AEMPTY_THRESH  4   raempty asserts when fill level <= this value (0..2**ADDRSIZE)
// PORTS
//  rclk      in   1           read clock; sole clock of the block
//  rrst_n    in   1           asynchronous, active-low reset
//  rinc      in   1           read request; honoured only when rempty==0
//  wptr      in   ADDRSIZE+1  Gray write pointer from the write domain (asynchronous)
//  rerr_clr  in   1           clears rerr
//  raddr     out  ADDRSIZE    RAM read address = rbin[ADDRSIZE-1:0]
//  rptr      out  ADDRSIZE+1  registered Gray read pointer, exported to the write domain
//  rempty    out  1           FIFO empty (registered)
//  raempty   out  1           fill level <= AEMPTY_THRESH (registered)
//  rlevel    out  ADDRSIZE+1  fill level as seen from rclk, 0..2**ADDRSIZE (registered)
//  rerr      out  1           sticky underflow: rinc seen while rempty==1
// BEHAVIOUR
//  - Reset (async, rrst_n=0): rbin=0, rptr=0, sync flops=0, rempty=1, raempty=1, rlevel=0,
//    rerr=0. Outputs take reset values immediately, independent of rclk; applies mid-operation.
//  - Sync: rq1_wptr<=wptr, rq2_wptr<=rq1_wptr; 2 rclk edges latency; no other logic on wptr.
//  - rbinnext = rbin + (rinc & ~rempty); rgraynext = (rbinnext>>1) ^ rbinnext.
//    rbin<=rbinnext, rptr<=rgraynext every edge. Arithmetic modulo 2**(ADDRSIZE+1).
//  - rempty <= (rgraynext == rq2_wptr). Pop on the last word asserts rempty on that same edge.
//  - wbin_s = gray2bin(rq2_wptr) (combinational); lvl_next = wbin_s - rbinnext, ADDRSIZE+1 bits,
//    unsigned wrap. rlevel<=lvl_next; raempty<=(lvl_next<=AEMPTY_THRESH).
//    Invariant: rempty==1 iff rlevel==0, same edge.
//  - Level is conservative: new writes appear >=3 rclk edges after wptr changes (2 sync + 1 reg).
//  - Underflow: rinc & rempty -> no pointer change, rerr<=1. rerr_clr -> rerr<=0.
//    Set and clear in the same cycle: set wins.
//  - Wrap: rbin 2**(ADDRSIZE+1)-1 -> 0; raddr 2**ADDRSIZE-1 -> 0;
//    extra MSB distinguishes full from empty in the write domain.
//  - raddr is combinational from the rbin register: the RAM sees the new address the cycle after a pop.
// STRUCTURE
//  - Package fifo_pkg: ADDRSIZE default, functions bin2gray/gray2bin, localparam DEPTH=2**ADDRSIZE.
//  - Sub-module sync_w2r (two-flop wptr->rclk synchronizer, async clear on rrst_n), instanced once.
//  - Remaining logic (pointer, flags, level, err) lives flat in rptr_empty.
// TESTING  (ADDRSIZE=6, AEMPTY_THRESH=4)
//  1 Reset: rrst_n=0 mid-stream with rptr=0x05 -> rptr=0, raddr=0, rempty=1, raempty=1,
//    rlevel=0, rerr=0 before next rclk.
//  2 Sync latency: wptr 0x00->0x01 held -> rempty falls and rlevel=1 on 3rd rclk edge after change.
//  3 Drain: wptr=gray(5)=0x07, rinc=1 x5 -> rptr 0x01,0x03,0x02,0x06,0x07;
//    rlevel 4,3,2,1,0; rempty=1 on 5th edge.
//  4 Almost-empty: level 5 -> raempty=0; one pop -> rlevel=4, raempty=1 same edge.
//  5 Underflow: rinc=1 while empty -> rptr unchanged, rerr=1 next edge; rerr_clr -> 0;
//    rinc+rerr_clr together on empty -> rerr stays 1.
//  6 Wrap: stream 130 words with wptr tracking -> rbin 127->0, raddr 63->0, rptr 0x40->0x00,
//    rempty and rlevel consistent throughout.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer conversions.
// Conversions work on a fixed 16-bit word; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

  localparam int ADDRSIZE_DEFAULT = 6;
  localparam int DEPTH            = 2 ** ADDRSIZE_DEFAULT;
  localparam int PTR_MAX_W        = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits stay zero, so results truncated to a narrower pointer remain exact.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// Two-flop synchronizer carrying the Gray write pointer into the read clock domain.
module sync_w2r #(
  parameter int WIDTH = 7
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [WIDTH-1:0] wptr,
  output logic [WIDTH-1:0] rq2_wptr
);

  logic [WIDTH-1:0] rq1_wptr_d, rq1_wptr_q;
  logic [WIDTH-1:0] rq2_wptr_d, rq2_wptr_q;

  always_comb begin
    rq1_wptr_d = wptr;
    rq2_wptr_d = rq1_wptr_q;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
    end else begin
      rq1_wptr_q <= rq1_wptr_d;
      rq2_wptr_q <= rq2_wptr_d;
    end
  end

  assign rq2_wptr = rq2_wptr_q;

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer controller for the async FIFO: read pointer, registered empty/almost-empty,
// conservative fill level and sticky underflow flag.
module rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = ADDRSIZE_DEFAULT,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic                rerr_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rerr
);

  localparam int                PTR_W     = ADDRSIZE + 1;
  localparam logic [PTR_W-1:0]  AE_THRESH = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] rq2_wptr;
  logic [PTR_W-1:0] wbin_s;
  logic             rd_ok;

  logic [PTR_W-1:0] rbin_d,    rbin_q;
  logic [PTR_W-1:0] rgray_d,   rgray_q;
  logic [PTR_W-1:0] rlevel_d,  rlevel_q;
  logic             rempty_d,  rempty_q;
  logic             raempty_d, raempty_q;
  logic             rerr_d,    rerr_q;

  sync_w2r #(
    .WIDTH (PTR_W)
  ) u_sync_w2r (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .wptr     (wptr),
    .rq2_wptr (rq2_wptr)
  );

  // Flags and level are computed from the next pointer so a final pop empties on the same edge.
  always_comb begin
    rd_ok     = rinc & ~rempty_q;
    rbin_d    = rbin_q + PTR_W'(rd_ok);
    rgray_d   = PTR_W'(bin2gray(PTR_MAX_W'(rbin_d)));
    wbin_s    = PTR_W'(gray2bin(PTR_MAX_W'(rq2_wptr)));
    rlevel_d  = wbin_s - rbin_d;
    rempty_d  = (rgray_d == rq2_wptr);
    raempty_d = (rlevel_d <= AE_THRESH);
    rerr_d    = (rinc & rempty_q) | (rerr_q & ~rerr_clr);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rgray_q   <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rerr_q    <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rgray_q   <= rgray_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      rerr_q    <= rerr_d;
    end
  end

  assign raddr   = rbin_q[ADDRSIZE-1:0];
  assign rptr    = rgray_q;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;
  assign rerr    = rerr_q;

endmodule
